reg_file_param: RTL and testbench



---
 rtl/reg_file_param.sv | 135 +++++++++++++
 tb/tb_reg_file_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two read ports (Rs/Rt), one write port, optional hardwired r0,
// and a built-in sequencer that zeroes every entry after reset and on a clear request.
module reg_file_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned READ_LAT = 0
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              clr,
   input  logic              regWr,
   input  logic [ADDR_W-1:0] WriteAddr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] RsAddr,
   input  logic [ADDR_W-1:0] RtAddr,
   output logic [DATA_W-1:0] RsData,
   output logic [DATA_W-1:0] RtData,
   output logic              busy,
   output logic              clr_done,
   output logic              wr_err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} stateT;

   stateT             state;
   stateT             nextState;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] nextPtr;
   logic              nextBusy;
   logic              nextDone;
   logic              nextErr;
   logic              wrAccept;
   logic              clrWrite;
   logic              rsMask;
   logic              rtMask;
   logic              rdBlock;
   logic [DATA_W-1:0] rsRaw;
   logic [DATA_W-1:0] rtRaw;
   logic [DATA_W-1:0] rf [DEPTH];

   // State register and registered status outputs
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         ptr      <= '0;
         busy     <= 1'b1;
         clr_done <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         state    <= nextState;
         ptr      <= nextPtr;
         busy     <= nextBusy;
         clr_done <= nextDone;
         wr_err   <= nextErr;
      end
   end

   // Next state; a clear request always restarts the pass at entry 0 without clearing on that edge
   always_comb begin
      nextState = state;
      nextPtr   = ptr;
      case (state)
         CLEAR: begin
            if (clr) begin
               nextPtr = '0;
            end else begin
               nextPtr = ptr + ADDR_W'(1);
               if (ptr == LAST_ADDR) nextState = IDLE;
            end
         end
         IDLE: begin
            if (clr) begin
               nextState = CLEAR;
               nextPtr   = '0;
            end
         end
         default: nextState = CLEAR;
      endcase
   end

   // Outputs and array strobes
   always_comb begin
      nextBusy = 1'b0;
      nextDone = 1'b0;
      nextErr  = 1'b0;
      wrAccept = 1'b0;
      clrWrite = 1'b0;
      nextBusy = (nextState == CLEAR);
      nextDone = (state == CLEAR) && (nextState == IDLE);
      nextErr  = regWr && ((state == CLEAR) || clr);
      clrWrite = (state == CLEAR) && !clr;
      wrAccept = (state == IDLE) && !clr && regWr
                 && !((ZERO_REG != 0) && (WriteAddr == '0));
   end

   always_ff @(posedge CLK) begin
      if (clrWrite)      rf[ptr]       <= '0;
      else if (wrAccept) rf[WriteAddr] <= WriteData;
   end

   // Raw read values with same-cycle write bypass
   always_comb begin
      rsRaw = rf[RsAddr];
      rtRaw = rf[RtAddr];
      if (wrAccept && (WriteAddr == RsAddr)) rsRaw = WriteData;
      if (wrAccept && (WriteAddr == RtAddr)) rtRaw = WriteData;
   end

   assign rsMask = (ZERO_REG != 0) && (RsAddr == '0);
   assign rtMask = (ZERO_REG != 0) && (RtAddr == '0);
   // Leaving CLEAR implies a full pass finished, so every entry is already zero
   assign rdBlock = (state == CLEAR) || (nextState == CLEAR);

   if (READ_LAT == 0) begin : gCombRead
      always_comb begin
         RsData = ((state == CLEAR) || rsMask) ? '0 : rsRaw;
         RtData = ((state == CLEAR) || rtMask) ? '0 : rtRaw;
      end
   end else begin : gRegRead
      always_ff @(posedge CLK or posedge reset) begin
         if (reset) begin
            RsData <= '0;
            RtData <= '0;
         end else begin
            RsData <= (rdBlock || rsMask) ? '0 : rsRaw;
            RtData <= (rdBlock || rtMask) ? '0 : rtRaw;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param: a combinational-read/zero-reg instance and a
// registered-read/plain-r0 instance share stimulus and are checked against a behavioural model.
module tb_reg_file_param;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 32;

   logic          CLK = 1'b0;
   logic          reset;
   logic          clr;
   logic          regWr;
   logic [AW-1:0] WriteAddr;
   logic [DW-1:0] WriteData;
   logic [AW-1:0] RsAddr;
   logic [AW-1:0] RtAddr;
   logic [DW-1:0] rsData0, rtData0, rsData1, rtData1;
   logic          busy0, done0, err0, busy1, done1, err1;

   int nChecks = 0;
   int nFails  = 0;

   // Reference state
   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] mem1 [DEPTH];
   bit            mBusy, mDone, mErr;
   int            mPtr;
   logic [DW-1:0] q1s, q1t;
   bit            sBusy, sDone;

   always #5 CLK = ~CLK;

   reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .READ_LAT(0)) dut0 (
      .CLK(CLK), .reset(reset), .clr(clr), .regWr(regWr),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .RsAddr(RsAddr), .RtAddr(RtAddr),
      .RsData(rsData0), .RtData(rtData0), .busy(busy0), .clr_done(done0), .wr_err(err0)
   );

   reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .READ_LAT(1)) dut1 (
      .CLK(CLK), .reset(reset), .clr(clr), .regWr(regWr),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .RsAddr(RsAddr), .RtAddr(RtAddr),
      .RsData(rsData1), .RtData(rtData1), .busy(busy1), .clr_done(done1), .wr_err(err1)
   );

   task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 1'b1;
      mPtr  = 0;
      mDone = 1'b0;
      mErr  = 1'b0;
      q1s   = '0;
      q1t   = '0;
   endtask

   // Expected combinational read of the zero-reg instance, from current inputs
   function automatic logic [DW-1:0] comb0(input logic [AW-1:0] a);
      if (mBusy || a == '0) return '0;
      if (!clr && regWr && WriteAddr == a) return WriteData;
      return mem0[a];
   endfunction

   // One clock edge of the behavioural model
   task automatic modelEdge();
      bit accept;
      bit nb;
      accept = !mBusy && !clr && regWr;
      if (mBusy) nb = clr || (mPtr != DEPTH - 1);
      else       nb = clr;
      q1s = (mBusy || nb) ? '0 : ((accept && WriteAddr == RsAddr) ? WriteData : mem1[RsAddr]);
      q1t = (mBusy || nb) ? '0 : ((accept && WriteAddr == RtAddr) ? WriteData : mem1[RtAddr]);
      mErr  = regWr && (mBusy || clr);
      mDone = 1'b0;
      if (mBusy) begin
         if (clr) begin
            mPtr = 0;
         end else begin
            mem0[mPtr] = '0;
            mem1[mPtr] = '0;
            if (mPtr == DEPTH - 1) begin
               mBusy = 1'b0;
               mDone = 1'b1;
               mPtr  = 0;
            end else begin
               mPtr = mPtr + 1;
            end
         end
      end else if (clr) begin
         mBusy = 1'b1;
         mPtr  = 0;
      end else if (accept) begin
         if (WriteAddr != '0) mem0[WriteAddr] = WriteData;
         mem1[WriteAddr] = WriteData;
      end
   endtask

   // Drive one cycle from a negedge, check comb reads, clock, check registered outputs
   task automatic step(input bit c, input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      clr = c; regWr = w; WriteAddr = wa; WriteData = wd; RsAddr = ra; RtAddr = rb;
      #1;
      checkVal("rs0", rsData0, comb0(ra));
      checkVal("rt0", rtData0, comb0(rb));
      @(posedge CLK);
      modelEdge();
      @(negedge CLK);
      checkVal("busy0", DW'(busy0), DW'(mBusy));
      checkVal("busy1", DW'(busy1), DW'(mBusy));
      checkVal("done0", DW'(done0), DW'(mDone));
      checkVal("done1", DW'(done1), DW'(mDone));
      checkVal("err0", DW'(err0), DW'(mErr));
      checkVal("err1", DW'(err1), DW'(mErr));
      checkVal("rs1", rsData1, q1s);
      checkVal("rt1", rtData1, q1t);
      sBusy = busy0;
      sDone = done0;
   endtask

   task automatic idleStep(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      step(1'b0, 1'b0, '0, '0, ra, rb);
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (mBusy && n < 40) begin
         idleStep(AW'($urandom), AW'($urandom));
         n++;
      end
      checkVal(tag, DW'(busy0), '0);
   endtask

   initial begin
      int busyCnt;
      int doneCnt;
      reset = 1'b1; clr = 1'b0; regWr = 1'b0; WriteAddr = '0; WriteData = '0;
      RsAddr = '0; RtAddr = '0;
      for (int i = 0; i < DEPTH; i++) begin mem0[i] = '0; mem1[i] = '0; end
      modelReset();
      repeat (2) @(negedge CLK);
      checkVal("rstBusy", DW'(busy0 & busy1), 32'd1);
      checkVal("rstDone", DW'(done0 | done1), '0);
      checkVal("rstErr", DW'(err0 | err1), '0);
      checkVal("rstRs1", rsData1, '0);
      reset = 1'b0;

      // Post-reset clear; writes during it are dropped
      doneCnt = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         step(1'b0, (i < DEPTH) ? 1'($urandom) : 1'b0, AW'($urandom), $urandom,
              AW'($urandom), AW'($urandom));
         if (sDone) doneCnt++;
      end
      checkVal("postRstDone", DW'(doneCnt), 32'd1);
      for (int i = 0; i < DEPTH; i++) idleStep(AW'(i), AW'(DEPTH - 1 - i));

      // Write r5 with bypass, then read back
      step(1'b0, 1'b1, AW'(5), 32'hDEADBEEF, AW'(5), AW'(5));
      checkVal("lat1wr5", rsData1, 32'hDEADBEEF);
      idleStep(AW'(5), AW'(5));
      checkVal("rd5", rsData0, 32'hDEADBEEF);

      // r0 write: masked on the zero-reg instance only
      step(1'b0, 1'b1, '0, 32'h12345678, '0, '0);
      idleStep('0, '0);
      checkVal("r0zero", rsData0, '0);
      checkVal("r0plain", rsData1, 32'h12345678);

      // Fill, then clear request with a colliding write
      for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), DW'(i), AW'(i), AW'(i - 1));
      step(1'b1, 1'b1, AW'(3), 32'h0BAD0BAD, AW'(3), AW'(3));
      checkVal("clrWrErr", DW'(err0), 32'd1);
      waitIdle("clrIdle");
      for (int i = 0; i < DEPTH; i++) idleStep(AW'(i), AW'(i));

      // Restart mid-sequence at ptr=10
      step(1'b1, 1'b0, '0, '0, '0, '0);
      repeat (10) idleStep(AW'($urandom), AW'($urandom));
      busyCnt = 0;
      doneCnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(i == 0, 1'b0, '0, '0, AW'($urandom), AW'($urandom));
         if (sBusy) busyCnt++;
         if (sDone) doneCnt++;
      end
      checkVal("restartBusy", DW'(busyCnt), 32'd32);
      checkVal("restartDone", DW'(doneCnt), 32'd1);

      // Random traffic with bypass-biased reads
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] wa;
         wa = AW'($urandom);
         step($urandom_range(0, 49) == 0, 1'($urandom), wa, $urandom,
              ($urandom_range(0, 2) == 0) ? wa : AW'($urandom),
              ($urandom_range(0, 2) == 0) ? wa : AW'($urandom));
      end

      // Registered write-first read, then asynchronous reset mid-stream
      waitIdle("lat1Idle");
      step(1'b0, 1'b1, AW'(7), 32'h000000A5, AW'(7), AW'(7));
      checkVal("lat1wf", rsData1, 32'h000000A5);
      regWr = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkVal("asyncRs1", rsData1, '0);
      checkVal("asyncBusy", DW'(busy0 & busy1), 32'd1);
      modelReset();
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         idleStep(AW'(7), AW'($urandom));
         if (sDone) doneCnt++;
      end
      checkVal("rstAgainDone", DW'(doneCnt), 32'd1);
      checkVal("r7Cleared", rsData1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
